rram_readout_seq: RTL and testbench

RRAM_READOUT_SEQ -- requirements
Module: rram_readout_seq

---
 rtl/rram_readout_seq.sv | 152 +++++++++++++++
 tb/tb_rram_readout_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rram_readout_seq.sv
// rram_readout_seq: frame sequencer for a column-muxed RRAM ADC readout.
// Each frame sweeps ADCSEL 0..MUX_RATIO-1. Every column is converted for
// CONV_CYCLES cycles and then offered as one valid/ready beat.
// Optional feature macro: RRAM_READOUT_SUM_EN adds a registered sum of all
// channel codes on SUM. Without the macro SUM is tied to zero.
module rram_readout_seq #(
    parameter int unsigned NUM_ADCS    = 32,
    parameter int unsigned ADC_BITS    = 4,
    parameter int unsigned MUX_RATIO   = 16,
    parameter int unsigned CONV_CYCLES = 4,
    localparam int unsigned SW = (MUX_RATIO > 1) ? $clog2(MUX_RATIO) : 1,
    localparam int unsigned AW = ADC_BITS + $clog2(NUM_ADCS),
    localparam int unsigned DW = NUM_ADCS * ADC_BITS
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          valid_i,
    output logic          ready_o,
    output logic          ADC_CONV,
    output logic [SW-1:0] ADCSEL,
    input  logic [DW-1:0] ADCout,
    output logic [DW-1:0] DOUT,
    output logic [SW-1:0] DOUT_SEL,
    output logic [AW-1:0] SUM,
    output logic          valid_o,
    input  logic          ready_i,
    output logic          BUSY,
    output logic          DONE
);

    localparam int unsigned CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CONV_CYCLES - 1);
    localparam logic [SW-1:0] SEL_LAST = SW'(MUX_RATIO - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        OUT  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] sel_d;
    logic          capture;
    logic          ready_d, busy_d, valid_d, done_d, conv_d;

    // State register with registered status flags decoded from the next state.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ADCSEL   <= '0;
            ready_o  <= 1'b1;
            BUSY     <= 1'b0;
            valid_o  <= 1'b0;
            DONE     <= 1'b0;
            ADC_CONV <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ADCSEL   <= sel_d;
            ready_o  <= ready_d;
            BUSY     <= busy_d;
            valid_o  <= valid_d;
            DONE     <= done_d;
            ADC_CONV <= conv_d;
        end
    end

    // Next-state, column select, conversion counter and output flag decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = ADCSEL;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (valid_i && ready_o) begin
                    state_d = CONV;
                    sel_d   = '0;
                    cnt_d   = '0;
                end
            end
            CONV: begin
                if (cnt_q == CNT_LAST) begin
                    capture = 1'b1;
                    state_d = OUT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            OUT: begin
                if (valid_o && ready_i) begin
                    if (ADCSEL == SEL_LAST) begin
                        state_d = FIN;
                    end else begin
                        sel_d   = ADCSEL + SW'(1);
                        cnt_d   = '0;
                        state_d = CONV;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        valid_d = (state_d == OUT);
        done_d  = (state_d == FIN);
        conv_d  = (state_d == CONV) && (state_q != CONV);
    end

    // Beat capture: codes and the column they came from, held through OUT.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            DOUT     <= '0;
            DOUT_SEL <= '0;
        end else if (capture) begin
            DOUT     <= ADCout;
            DOUT_SEL <= ADCSEL;
        end
    end

`ifdef RRAM_READOUT_SUM_EN
    logic [AW-1:0] sum_c;

    // Unsigned sum of all channel codes; AW is wide enough for NUM_ADCS max codes.
    always_comb begin
        sum_c = '0;
        for (int unsigned i = 0; i < NUM_ADCS; i++) begin
            sum_c = sum_c + AW'(ADCout[i*ADC_BITS +: ADC_BITS]);
        end
    end

    // Sum register, loaded on the same edge as DOUT.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            SUM <= '0;
        end else if (capture) begin
            SUM <= sum_c;
        end
    end
`else
    assign SUM = '0;
`endif

endmodule

// File: tb/tb_rram_readout_seq.sv
// Testbench for rram_readout_seq with default parameters.
// Edge numbering: a value observed just after edge e is what the DUT
// samples at edge e+1; latencies are counted in DUT-sampled edges.
module tb_rram_readout_seq;

    localparam int NUM_ADCS    = 32;
    localparam int ADC_BITS    = 4;
    localparam int MUX_RATIO   = 16;
    localparam int CONV_CYCLES = 4;
    localparam int SW          = 4;
    localparam int AW          = 9;
    localparam int DW          = NUM_ADCS * ADC_BITS;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic          ADC_CONV;
    logic [SW-1:0] ADCSEL;
    logic [DW-1:0] ADCout = '0;
    logic [DW-1:0] DOUT;
    logic [SW-1:0] DOUT_SEL;
    logic [AW-1:0] SUM;
    logic          valid_o;
    logic          ready_i = 1'b0;
    logic          BUSY;
    logic          DONE;

    int errors = 0;
    int checks = 0;

    rram_readout_seq dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .ADC_CONV (ADC_CONV),
        .ADCSEL   (ADCSEL),
        .ADCout   (ADCout),
        .DOUT     (DOUT),
        .DOUT_SEL (DOUT_SEL),
        .SUM      (SUM),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reset values of every output.
    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, DW'(ready_o), DW'(1));
        chk({tag, "_valid"}, DW'(valid_o), DW'(0));
        chk({tag, "_conv"},  DW'(ADC_CONV), DW'(0));
        chk({tag, "_busy"},  DW'(BUSY), DW'(0));
        chk({tag, "_done"},  DW'(DONE), DW'(0));
        chk({tag, "_sel"},   DW'(ADCSEL), DW'(0));
        chk({tag, "_dsel"},  DW'(DOUT_SEL), DW'(0));
        chk({tag, "_dout"},  DOUT, DW'(0));
        chk({tag, "_sum"},   DW'(SUM), DW'(0));
    endtask

    // Beat pattern: 0 random, 1 every code equals column index, 2 all codes max.
    function automatic logic [DW-1:0] make_pat(input int mode, input int col);
        logic [DW-1:0] p;
        p = '0;
        for (int i = 0; i < NUM_ADCS; i++) begin
            if (mode == 1)      p[i*ADC_BITS +: ADC_BITS] = ADC_BITS'(col);
            else if (mode == 2) p[i*ADC_BITS +: ADC_BITS] = '1;
            else                p[i*ADC_BITS +: ADC_BITS] = ADC_BITS'($urandom);
        end
        return p;
    endfunction

    function automatic int exp_sum(input logic [DW-1:0] p);
        int s;
        s = 0;
`ifdef RRAM_READOUT_SUM_EN
        for (int i = 0; i < NUM_ADCS; i++) s += int'(p[i*ADC_BITS +: ADC_BITS]);
`endif
        return s;
    endfunction

    // Run one frame from IDLE. stall_beat gets 10 cycles of ready_i=0,
    // busy_beat gets a valid_i pulse, abort_beat is reset mid-CONV.
    task automatic run_frame(input int mode, input int stall_pct, input int stall_beat,
                             input int busy_beat, input int abort_beat, input bit chk_timing);
        int k, edges, beat_start, last_xfer, dones, stall_left;
        bit prev_valid, hs, done_run;
        logic [DW-1:0] pat;
        k = 0; dones = 0; last_xfer = -100; prev_valid = 0; stall_left = 0; done_run = 0;
        pat = make_pat(mode, 0);
        ADCout = pat;
        chk("idle_ready", DW'(ready_o), DW'(1));
        valid_i = 1'b1;
        ready_i = 1'b0;
        tick();
        valid_i = 1'b0;
        edges = 0;
        beat_start = 0;
        chk("accept_busy", DW'({BUSY, ready_o}), DW'(2'b10));
        chk("accept_sel0", DW'(ADCSEL), DW'(0));
        chk("accept_conv", DW'(ADC_CONV), DW'(1));
        for (int cyc = 0; cyc < 2000 && !done_run; cyc++) begin
            if (valid_o) begin
                if (!prev_valid) begin
                    chk("beat_lat", DW'(edges + 1 - beat_start), DW'(CONV_CYCLES + 1));
                    chk("beat_dout", DOUT, pat);
                    chk("beat_dsel", DW'(DOUT_SEL), DW'(k));
                    chk("beat_sel", DW'(ADCSEL), DW'(k));
                    chk("beat_sum", DW'(SUM), DW'(exp_sum(pat)));
                    if (k == stall_beat) stall_left = 10;
                    if (k == busy_beat) begin
                        valid_i = 1'b1;
                        chk("busy_ready", DW'(ready_o), DW'(0));
                    end
                end else if (k == stall_beat) begin
                    chk("stall_dout", DOUT, pat);
                    chk("stall_dsel", DW'(DOUT_SEL), DW'(k));
                    chk("stall_sel", DW'(ADCSEL), DW'(k));
                    chk("stall_conv", DW'(ADC_CONV), DW'(0));
                end
                ADCout = make_pat(0, 0);
                if (stall_left > 0) begin
                    ready_i = 1'b0;
                    stall_left--;
                end else begin
                    ready_i = ($urandom_range(99) >= stall_pct);
                end
            end else begin
                ready_i = 1'($urandom_range(1));
            end
            hs = valid_o && ready_i;
            prev_valid = valid_o;
            tick();
            edges++;
            valid_i = 1'b0;
            if (hs) begin
                last_xfer = edges;
                k++;
                prev_valid = 0;
                if (k < MUX_RATIO) begin
                    pat = make_pat(mode, k);
                    ADCout = pat;
                    beat_start = edges;
                    chk("next_conv", DW'(ADC_CONV), DW'(1));
                    chk("next_sel", DW'(ADCSEL), DW'(k));
                    if (k == abort_beat) begin
                        RESET_N = 1'b0;
                        #1;
                        chk_reset("abort");
                        tick();
                        tick();
                        RESET_N = 1'b1;
                        chk_reset("abort_rel");
                        return;
                    end
                end
            end
            if (DONE) begin
                dones++;
                chk("done_edge", DW'(edges + 1), DW'(last_xfer + 1));
            end
            if (k == MUX_RATIO && edges >= last_xfer + 1) done_run = 1;
        end
        ready_i = 1'b0;
        chk("frame_beats", DW'(k), DW'(MUX_RATIO));
        chk("frame_dones", DW'(dones), DW'(1));
        chk("end_ready", DW'({ready_o, BUSY}), DW'(2'b10));
        chk("end_sel_hold", DW'(ADCSEL), DW'(MUX_RATIO - 1));
        if (chk_timing) chk("last_xfer_edge", DW'(last_xfer), DW'(MUX_RATIO * (CONV_CYCLES + 1)));
    endtask

    initial begin
        // Reset held low.
        tick();
        tick();
        chk_reset("rst");
        RESET_N = 1'b1;
        tick();
        chk_reset("post_rst");

        // Full frame, codes equal column, no backpressure.
        run_frame(1, 0, -1, -1, -1, 1'b1);
        tick();

        // Backpressure at beat 3 plus a busy start pulse at beat 5.
        run_frame(1, 0, 3, 5, -1, 1'b0);
        tick();

        // Abort at beat 7, then a clean frame from column 0.
        run_frame(0, 20, -1, -1, 7, 1'b0);
        tick();
        run_frame(0, 0, -1, -1, -1, 1'b1);
        tick();

        // All codes at maximum: SUM 480 or 0 depending on the build.
        run_frame(2, 0, -1, -1, -1, 1'b1);
`ifdef RRAM_READOUT_SUM_EN
        chk("sum_max", DW'(SUM), DW'(480));
`else
        chk("sum_max", DW'(SUM), DW'(0));
`endif
        tick();

        // Random codes with random backpressure.
        for (int f = 0; f < 3; f++) begin
            run_frame(0, 40, -1, -1, -1, 1'b0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
